read_buffer: RTL and testbench



---
 rtl/pr_pkg.sv | 14 +
 rtl/addr_parser.sv | 25 ++
 rtl/read_buffer.sv | 108 ++++++++++
 tb/tb_read_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pr_pkg.sv
// Shared constants and helpers for the PageRank read path.
// Provides beat/word widths and the words-per-beat calculation.
package pr_pkg;

    localparam int BEAT_W     = 512;
    localparam int INT_W      = 64;
    localparam int WORD_IDX_W = 8;

    // Number of WIDTH-bit words packed into one beat.
    function automatic int words_per_beat(int full_w, int w);
        return full_w / w;
    endfunction

endpackage

// File: rtl/addr_parser.sv
// Combinational big-endian word selector: word 0 is the beat MSBs.
// Ports: valid (gate), idx (word index), data (beat), out (word or 0).
module addr_parser
    import pr_pkg::*;
#(
    parameter int FULL_WIDTH = BEAT_W,
    parameter int WIDTH      = INT_W,
    localparam int WORDS     = words_per_beat(FULL_WIDTH, WIDTH),
    localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  valid,
    input  logic [IDX_W-1:0]      idx,
    input  logic [FULL_WIDTH-1:0] data,
    output logic [WIDTH-1:0]      out
);

    logic [WIDTH-1:0] w_words [WORDS];

    for (genvar g = 0; g < WORDS; g++) begin : g_word
        assign w_words[g] = data[FULL_WIDTH-1-g*WIDTH -: WIDTH];
    end

    assign out = valid ? w_words[idx] : '0;

endmodule

// File: rtl/read_buffer.sv
// Beat-to-word unpacker: captures one beat, emits words [base, end).
// Ports: clk, rst, rready/rdata/base/bounds in; odata_req in; oready/odata out.
module read_buffer
    import pr_pkg::*;
#(
    parameter int FULL_WIDTH = BEAT_W,
    parameter int WIDTH      = INT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rready,
    input  logic [FULL_WIDTH-1:0] rdata,
    input  logic                  odata_req,
    input  logic [WORD_IDX_W-1:0] base,
    input  logic [WORD_IDX_W-1:0] bounds,
    output logic                  oready,
    output logic [WIDTH-1:0]      odata
);

    localparam int WORDS = words_per_beat(FULL_WIDTH, WIDTH);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WORD_IDX_W-1:0] WORDS_B = WORD_IDX_W'(WORDS);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                r_state, w_state_n;
    logic [FULL_WIDTH-1:0] r_data,  w_data_n;
    logic [WORD_IDX_W-1:0] r_idx,   w_idx_n;
    logic [WORD_IDX_W-1:0] r_end,   w_end_n;

    logic                  w_valid;
    logic                  w_xfer;
    logic                  w_last;
    logic [WORD_IDX_W-1:0] w_idx_inc;
    logic [WORD_IDX_W-1:0] w_end_clamp;
    logic                  w_range_ok;

    assign w_valid     = (r_state == DRAIN);
    assign w_xfer      = w_valid && odata_req;
    assign w_idx_inc   = r_idx + WORD_IDX_W'(1);
    assign w_last      = w_xfer && (w_idx_inc == r_end);
    assign w_end_clamp = (bounds > WORDS_B) ? WORDS_B : bounds;
    assign w_range_ok  = (base < w_end_clamp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_idx   <= '0;
            r_end   <= '0;
        end else begin
            r_state <= w_state_n;
            r_data  <= w_data_n;
            r_idx   <= w_idx_n;
            r_end   <= w_end_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_data_n  = r_data;
        w_idx_n   = r_idx;
        w_end_n   = r_end;
        unique case (r_state)
            EMPTY: begin
                if (rready) begin
                    w_data_n  = rdata;
                    w_idx_n   = base;
                    w_end_n   = w_end_clamp;
                    w_state_n = w_range_ok ? DRAIN : EMPTY;
                end
            end
            DRAIN: begin
                if (w_xfer) begin
                    w_idx_n = w_idx_inc;
                end
                // A beat is only taken on the final-word cycle; it loads
                // straight in so the next word follows with no bubble.
                if (w_last) begin
                    w_state_n = EMPTY;
                    if (rready) begin
                        w_data_n  = rdata;
                        w_idx_n   = base;
                        w_end_n   = w_end_clamp;
                        w_state_n = w_range_ok ? DRAIN : EMPTY;
                    end
                end
            end
            default: w_state_n = EMPTY;
        endcase
    end

    assign oready = w_valid;

    addr_parser #(
        .FULL_WIDTH (FULL_WIDTH),
        .WIDTH      (WIDTH)
    ) u_sel (
        .valid (w_valid),
        .idx   (r_idx[IDX_W-1:0]),
        .data  (r_data),
        .out   (odata)
    );

endmodule

// File: tb/tb_read_buffer.sv
// Testbench for read_buffer: 64-bit and 128-bit instances share stimulus
// and are checked every cycle against a word-queue reference model.
module tb_read_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         rready;
    logic [511:0] rdata;
    logic         odata_req;
    logic [7:0]   base;
    logic [7:0]   bounds;
    logic         oready64;
    logic [63:0]  odata64;
    logic         oready128;
    logic [127:0] odata128;

    int checks = 0;
    int errors = 0;

    logic [63:0]  q64  [$];
    logic [127:0] q128 [$];

    always #5 clk = ~clk;

    read_buffer #(.FULL_WIDTH(512), .WIDTH(64)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .rready    (rready),
        .rdata     (rdata),
        .odata_req (odata_req),
        .base      (base),
        .bounds    (bounds),
        .oready    (oready64),
        .odata     (odata64)
    );

    read_buffer #(.FULL_WIDTH(512), .WIDTH(128)) u_dut128 (
        .clk       (clk),
        .rst       (rst),
        .rready    (rready),
        .rdata     (rdata),
        .odata_req (odata_req),
        .base      (base),
        .bounds    (bounds),
        .oready    (oready128),
        .odata     (odata128)
    );

    function automatic logic [511:0] rand_beat();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // One clock of the reference: pop on transfer, push the new range
    // when a beat lands in an empty buffer or on the final-word cycle.
    task automatic model_64();
        bit xfer, last, acc;
        int e;
        logic [511:0] t;
        xfer = (q64.size() > 0) && odata_req;
        last = xfer && (q64.size() == 1);
        acc  = rready && ((q64.size() == 0) || last);
        if (xfer) void'(q64.pop_front());
        if (acc) begin
            e = (bounds > 8) ? 8 : int'(bounds);
            for (int i = int'(base); i < e; i++) begin
                t = rdata << (i * 64);
                q64.push_back(t[511:448]);
            end
        end
    endtask

    task automatic model_128();
        bit xfer, last, acc;
        int e;
        logic [511:0] t;
        xfer = (q128.size() > 0) && odata_req;
        last = xfer && (q128.size() == 1);
        acc  = rready && ((q128.size() == 0) || last);
        if (xfer) void'(q128.pop_front());
        if (acc) begin
            e = (bounds > 4) ? 4 : int'(bounds);
            for (int i = int'(base); i < e; i++) begin
                t = rdata << (i * 128);
                q128.push_back(t[511:384]);
            end
        end
    endtask

    task automatic check(string tag);
        logic         er64, er128;
        logic [63:0]  ed64;
        logic [127:0] ed128;
        er64  = (q64.size() > 0);
        ed64  = er64 ? q64[0] : 64'd0;
        er128 = (q128.size() > 0);
        ed128 = er128 ? q128[0] : 128'd0;
        checks += 4;
        assert (oready64 === er64) else begin
            errors++;
            $error("FAIL %s oready64 got %b exp %b", tag, oready64, er64);
        end
        assert (odata64 === ed64) else begin
            errors++;
            $error("FAIL %s odata64 got %h exp %h", tag, odata64, ed64);
        end
        assert (oready128 === er128) else begin
            errors++;
            $error("FAIL %s oready128 got %b exp %b", tag, oready128, er128);
        end
        assert (odata128 === ed128) else begin
            errors++;
            $error("FAIL %s odata128 got %h exp %h", tag, odata128, ed128);
        end
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_64();
        model_128();
        #1;
        check(tag);
    endtask

    task automatic beat(logic [7:0] b, logic [7:0] e);
        rready = 1'b1;
        rdata  = rand_beat();
        base   = b;
        bounds = e;
    endtask

    initial begin
        rst       = 1'b1;
        rready    = 1'b0;
        rdata     = '0;
        odata_req = 1'b1;
        base      = '0;
        bounds    = '0;
        #12;
        check("reset");
        rst = 1'b0;
        #20;
        check("idle");

        // Full range 0..4
        beat(8'd0, 8'd4);
        step("full_load");
        rready = 1'b0;
        for (int i = 0; i < 6; i++) step("full_drain");

        // Partial range 3..8 with a two-cycle stall
        beat(8'd3, 8'd8);
        step("part_load");
        rready = 1'b0;
        step("part_c1");
        odata_req = 1'b0;
        step("part_stall1");
        step("part_stall2");
        odata_req = 1'b1;
        for (int i = 0; i < 6; i++) step("part_drain");

        // Bounds clamped to word count
        beat(8'd0, 8'd20);
        step("clamp_load");
        rready = 1'b0;
        for (int i = 0; i < 9; i++) step("clamp_drain");

        // Empty range is discarded
        beat(8'd5, 8'd5);
        step("empty_load");
        rready = 1'b0;
        step("empty_idle");
        beat(8'd2, 8'd1);
        step("inv_load");
        rready = 1'b0;
        step("inv_idle");

        // Drop mid-drain, then back-to-back on the last word
        beat(8'd0, 8'd4);
        step("b2b_load1");
        rready = 1'b0;
        step("b2b_w1");
        beat(8'd1, 8'd3);
        step("drop");
        rready = 1'b0;
        step("b2b_w3");
        beat(8'd1, 8'd3);
        step("b2b_load2");
        rready = 1'b0;
        for (int i = 0; i < 4; i++) step("b2b_drain");

        // Reset in the middle of a drain
        beat(8'd0, 8'd4);
        step("rst_load");
        rready = 1'b0;
        step("rst_w1");
        #3;
        rst = 1'b1;
        q64.delete();
        q128.delete();
        #1;
        check("rst_mid");
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("rst_after");

        // Randomised traffic
        for (int c = 0; c < 300; c++) begin
            rready    = ($urandom_range(0, 2) == 0);
            rdata     = rand_beat();
            base      = 8'($urandom_range(0, 9));
            bounds    = 8'($urandom_range(0, 10));
            odata_req = ($urandom_range(0, 3) != 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
